// File: rtl/axi_io_pmp_pkg.sv
// Shared AXI response codes and FSM state types for the IO-PMP error responder.
package axi_io_pmp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_err_rd_gen.sv
// Read side of the error responder: accepts one AR and plays out arlen+1 error beats.
module axi_err_rd_gen
  import axi_io_pmp_pkg::*;
#(
  parameter int ID_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [7:0]          arlen,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_WIDTH-1:0] rid,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  output logic                rd_done
);

  rd_state_e  state;
  logic [7:0] beats_left;

  // beats_left counts down to zero and the burst ends there, so arlen=255 gives 256 beats without wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= R_IDLE;
      beats_left <= '0;
      rid        <= '0;
    end else if (state == R_IDLE) begin
      if (arvalid) begin
        state      <= R_DATA;
        rid        <= arid;
        beats_left <= arlen;
      end
    end else if (rready) begin
      if (beats_left == 8'd0) state <= R_IDLE;
      else                    beats_left <= beats_left - 8'd1;
    end
  end

  assign arready = (state == R_IDLE);
  assign rvalid  = (state == R_DATA);
  assign rlast   = rvalid && (beats_left == 8'd0);
  assign rd_done = rvalid && rready && rlast;

endmodule

// File: rtl/axi_io_pmp_err_slv.sv
// AXI4 sink for PMP-denied traffic: completes writes and reads with an error response
// and keeps saturating per-direction counts of completed denials.
module axi_io_pmp_err_slv
  import axi_io_pmp_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ID_WIDTH    = 8,
  parameter int          BUSER_WIDTH = 1,
  parameter int          RUSER_WIDTH = 1,
  parameter logic [1:0]  RESP        = RESP_SLVERR,
  parameter logic [31:0] RDATA_FILL  = 32'hDEAD_BEEF,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ID_WIDTH-1:0]    s_axi_awid,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic                   s_axi_wlast,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [ID_WIDTH-1:0]    s_axi_bid,
  output logic [1:0]             s_axi_bresp,
  output logic [BUSER_WIDTH-1:0] s_axi_buser,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [ID_WIDTH-1:0]    s_axi_arid,
  input  logic [7:0]             s_axi_arlen,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [ID_WIDTH-1:0]    s_axi_rid,
  output logic [DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rlast,
  output logic [RUSER_WIDTH-1:0] s_axi_ruser,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  input  logic                   cnt_clear,
  output logic [CNT_WIDTH-1:0]   wr_err_cnt,
  output logic [CNT_WIDTH-1:0]   rd_err_cnt
);

  localparam int                     FILL_REPS = (DATA_WIDTH + 31) / 32;
  localparam logic [FILL_REPS*32-1:0] FILL_WIDE = {FILL_REPS{RDATA_FILL}};

  wr_state_e w_state;
  logic      wr_done;
  logic      rd_done;

  // Write beats are drained without looking at awlen; wlast alone ends the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      s_axi_bid <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (s_axi_awvalid) begin
          w_state   <= W_DATA;
          s_axi_bid <= s_axi_awid;
        end
        W_DATA: if (s_axi_wvalid && s_axi_wlast) w_state <= W_RESP;
        W_RESP: if (s_axi_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign s_axi_awready = (w_state == W_IDLE);
  assign s_axi_wready  = (w_state == W_DATA);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_bresp   = RESP;
  assign s_axi_buser   = '0;
  assign wr_done       = s_axi_bvalid && s_axi_bready;

  axi_err_rd_gen #(
    .ID_WIDTH (ID_WIDTH)
  ) u_rd_gen (
    .clk     (clk),
    .rst     (rst),
    .arid    (s_axi_arid),
    .arlen   (s_axi_arlen),
    .arvalid (s_axi_arvalid),
    .arready (s_axi_arready),
    .rid     (s_axi_rid),
    .rlast   (s_axi_rlast),
    .rvalid  (s_axi_rvalid),
    .rready  (s_axi_rready),
    .rd_done (rd_done)
  );

  assign s_axi_rdata = FILL_WIDE[DATA_WIDTH-1:0];
  assign s_axi_rresp = RESP;
  assign s_axi_ruser = '0;

  // Clear takes priority over a same-cycle completion; counts stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err_cnt <= '0;
      rd_err_cnt <= '0;
    end else if (cnt_clear) begin
      wr_err_cnt <= '0;
      rd_err_cnt <= '0;
    end else begin
      if (wr_done && (wr_err_cnt != '1)) wr_err_cnt <= wr_err_cnt + CNT_WIDTH'(1);
      if (rd_done && (rd_err_cnt != '1)) rd_err_cnt <= rd_err_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axi_io_pmp_err_slv.sv
// Randomized scoreboard bench for axi_io_pmp_err_slv; a narrow-counter twin shares the stimulus
// so counter saturation can be reached quickly.
module tb_axi_io_pmp_err_slv;

  typedef struct {
    logic [7:0] id;
    logic       last;
  } rbeat_t;

  logic        clk = 0;
  logic        rst = 1;
  logic [7:0]  awid = 0, arid = 0, arlen = 0;
  logic        awvalid = 0, wlast = 0, wvalid = 0, bready = 0;
  logic        arvalid = 0, rready = 0, cnt_clear = 0;
  logic        awready, wready, bvalid, rlast, rvalid, arready;
  logic [7:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [0:0]  buser, ruser;
  logic [31:0] rdata;
  logic [15:0] wr_err_cnt, rd_err_cnt;

  logic        s_awready, s_wready, s_bvalid, s_rlast, s_rvalid, s_arready;
  logic [7:0]  s_bid, s_rid;
  logic [1:0]  s_bresp, s_rresp;
  logic [0:0]  s_buser, s_ruser;
  logic [31:0] s_rdata;
  logic [2:0]  s_wr_cnt, s_rd_cnt;

  int n_vec = 0, n_err = 0;
  int b_pat = 0, r_pat = 0;     // 0 always ready, 1 random, 2 toggle, 3 held low, 4 manual
  logic [7:0] exp_b[$];
  rbeat_t     exp_r[$];
  longint     wr_m = 0, rd_m = 0;
  bit f_wready, f_bvalid, f_awready, f_rvalid, f_arready;
  bit b_held, r_held;
  logic [7:0] b_hold_id, r_hold_id;
  logic       r_hold_last;

  always #5 clk = ~clk;

  axi_io_pmp_err_slv dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_buser(buser),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_arlen(arlen), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_ruser(ruser), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .cnt_clear(cnt_clear), .wr_err_cnt(wr_err_cnt), .rd_err_cnt(rd_err_cnt)
  );

  axi_io_pmp_err_slv #(.CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awvalid(awvalid), .s_axi_awready(s_awready),
    .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(s_wready),
    .s_axi_bid(s_bid), .s_axi_bresp(s_bresp), .s_axi_buser(s_buser),
    .s_axi_bvalid(s_bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_arlen(arlen), .s_axi_arvalid(arvalid), .s_axi_arready(s_arready),
    .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
    .s_axi_ruser(s_ruser), .s_axi_rvalid(s_rvalid), .s_axi_rready(rready),
    .cnt_clear(cnt_clear), .wr_err_cnt(s_wr_cnt), .rd_err_cnt(s_rd_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  function automatic longint sat(input longint v, input int w);
    longint m = (64'd1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // Ready drivers for B and R.
  initial forever begin
    @(posedge clk); #1;
    case (b_pat)
      0: bready = 1;
      1: bready = 1'($urandom_range(0, 1));
      2: bready = ~bready;
      3: bready = 0;
      default: ;
    endcase
    case (r_pat)
      0: rready = 1;
      1: rready = 1'($urandom_range(0, 1));
      2: rready = ~rready;
      3: rready = 0;
      default: ;
    endcase
  end

  // Monitor: compares every B/R handshake, payload hold, latencies and counters.
  initial forever begin
    bit wr_inc, rd_inc;
    logic [7:0] eb;
    rbeat_t er;
    @(negedge clk);
    if (!rst) begin
      wr_inc = 0;
      rd_inc = 0;
      chk("wr_err_cnt", 64'(wr_err_cnt), 64'(sat(wr_m, 16)));
      chk("rd_err_cnt", 64'(rd_err_cnt), 64'(sat(rd_m, 16)));
      chk("wr_err_cnt_sat3", 64'(s_wr_cnt), 64'(sat(wr_m, 3)));
      chk("rd_err_cnt_sat3", 64'(s_rd_cnt), 64'(sat(rd_m, 3)));
      if (f_wready)  chk("wready_after_aw", 64'(wready), 64'd1);
      if (f_bvalid)  chk("bvalid_after_wlast", 64'(bvalid), 64'd1);
      if (f_awready) chk("awready_after_b", 64'(awready), 64'd1);
      if (f_rvalid)  chk("rvalid_after_ar", 64'(rvalid), 64'd1);
      if (f_arready) chk("arready_after_rlast", 64'(arready), 64'd1);
      {f_wready, f_bvalid, f_awready, f_rvalid, f_arready} = '0;
      if (b_held) begin
        chk("b_hold_valid", 64'(bvalid), 64'd1);
        chk("b_hold_id", 64'(bid), 64'(b_hold_id));
      end
      b_held = 0;
      if (bvalid) begin
        if (bready) begin
          if (exp_b.size() == 0) fail("b_unexpected");
          else begin
            eb = exp_b.pop_front();
            chk("bid", 64'(bid), 64'(eb));
            chk("bresp", 64'(bresp), 64'h2);
            chk("buser", 64'(buser), 64'h0);
            wr_inc = 1;
            f_awready = 1;
          end
        end else begin
          b_held = 1;
          b_hold_id = bid;
        end
      end
      if (r_held) begin
        chk("r_hold_valid", 64'(rvalid), 64'd1);
        chk("r_hold_id", 64'(rid), 64'(r_hold_id));
        chk("r_hold_last", 64'(rlast), 64'(r_hold_last));
      end
      r_held = 0;
      if (rvalid) begin
        if (rready) begin
          if (exp_r.size() == 0) fail("r_unexpected");
          else begin
            er = exp_r.pop_front();
            chk("rid", 64'(rid), 64'(er.id));
            chk("rlast", 64'(rlast), 64'(er.last));
            chk("rdata", 64'(rdata), 64'hDEADBEEF);
            chk("rresp", 64'(rresp), 64'h2);
            chk("ruser", 64'(ruser), 64'h0);
            if (er.last) begin
              rd_inc = 1;
              f_arready = 1;
            end
          end
        end else begin
          r_held = 1;
          r_hold_id = rid;
          r_hold_last = rlast;
        end
      end
      if (awvalid && awready)        f_wready = 1;
      if (wvalid && wready && wlast) f_bvalid = 1;
      if (arvalid && arready)        f_rvalid = 1;
      if (cnt_clear) begin
        wr_m = 0;
        rd_m = 0;
      end else begin
        wr_m += wr_inc;
        rd_m += rd_inc;
      end
    end
  end

  task automatic do_write(input logic [7:0] id, input int nb, input bit early);
    int beat = 0, t = 0;
    bit aw_hs, w_hs;
    exp_b.push_back(id);
    awid = id;
    awvalid = 1;
    if (early) begin
      wvalid = 1;
      wlast = (nb == 1);
    end
    while ((awvalid || beat < nb) && t < 2000) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      @(posedge clk); #1;
      t++;
      if (aw_hs) awvalid = 0;
      if (w_hs) beat++;
      if (!wvalid || w_hs) begin
        wvalid = (beat < nb) && (early || !awvalid) && ($urandom_range(0, 3) != 0);
        wlast = (beat == nb - 1);
      end
    end
    wvalid = 0;
    awvalid = 0;
    if (t >= 2000) fail("write_timeout");
  endtask

  task automatic do_read(input logic [7:0] id, input logic [7:0] len);
    int t = 0;
    bit hs = 0;
    for (int i = 0; i <= int'(len); i++) exp_r.push_back('{id: id, last: (i == int'(len))});
    arid = id;
    arlen = len;
    arvalid = 1;
    while (!hs && t < 3000) begin
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      t++;
    end
    arvalid = 0;
    if (!hs) fail("read_ar_timeout");
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) fail("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_bid", 64'(bid), 64'd0);
    chk("rst_rid", 64'(rid), 64'd0);
    chk("rst_wr_cnt", 64'(wr_err_cnt), 64'd0);
    chk("rst_rd_cnt", 64'(rd_err_cnt), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    check_reset_vals();
    exp_b.delete();
    exp_r.delete();
    wr_m = 0;
    rd_m = 0;
    {f_wready, f_bvalid, f_awready, f_rvalid, f_arready} = '0;
    b_held = 0;
    r_held = 0;
    {awvalid, wvalid, arvalid} = '0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 0;
    @(posedge clk); #1;

    // Single-beat write, then a 4-beat read, all partners ready.
    do_write(8'h3C, 1, 0);
    drain();
    chk("single_write_cnt", 64'(wr_err_cnt), 64'd1);
    do_read(8'h11, 8'd3);
    drain();
    chk("read4_cnt", 64'(rd_err_cnt), 64'd1);

    // Full-length burst with rready toggling.
    r_pat = 2;
    do_read(8'h5A, 8'd255);
    drain();
    r_pat = 0;

    // Concurrent write and read with B stalled.
    b_pat = 3;
    fork
      do_write(8'h77, 4, 1);
      do_read(8'h66, 8'd1);
    join
    repeat (5) @(posedge clk);
    #1;
    b_pat = 0;
    drain();

    // Randomized concurrent traffic.
    for (int i = 0; i < 30; i++) begin
      b_pat = $urandom_range(0, 2);
      r_pat = $urandom_range(0, 2);
      fork
        do_write(8'($urandom), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
        do_read(8'($urandom), 8'($urandom_range(0, 12)));
      join
    end
    b_pat = 0;
    r_pat = 0;
    drain();
    do_write(8'h01, 2, 0);
    drain();
    chk("sat3_wr_hold", 64'(s_wr_cnt), 64'd7);

    // Clear coinciding with a B handshake.
    b_pat = 4;
    bready = 0;
    do_write(8'h42, 1, 0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bvalid && t < 100);
    if (!bvalid) fail("clr_bvalid_timeout");
    @(posedge clk); #1;
    bready = 1;
    cnt_clear = 1;
    @(posedge clk); #1;
    bready = 0;
    cnt_clear = 0;
    b_pat = 0;
    chk("clr_wins_wr", 64'(wr_err_cnt), 64'd0);
    chk("clr_wins_sat3", 64'(s_wr_cnt), 64'd0);
    drain();

    // Reset during beat 2 of an 8-beat read, then a single-beat read.
    do_read(8'h33, 8'd7);
    @(posedge clk); #1;
    do_reset();
    do_read(8'h22, 8'd0);
    drain();
    chk("post_rst_rd_cnt", 64'(rd_err_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
